demux1a8w4_stream: RTL and testbench

//  Registered 1-to-N stream distributor; the inverse of the 8:1 4-bit select mux.

---
 rtl/demux1a8w4_stream_pkg.sv | 11 +
 rtl/demux1a8w4_stream_if.sv | 32 +++
 rtl/demux1a8w4_stream_chan_slot.sv | 27 ++
 rtl/demux1a8w4_stream.sv | 84 ++++++++
 tb/tb_demux1a8w4_stream.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/demux1a8w4_stream_pkg.sv
// Shared sizing and types for the 1-to-N stream distributor (demux1a8w4_stream).
package demux_pkg;
  localparam int WIDTH = 4;
  localparam int N_CH  = 8;
  localparam int SEL_W = $clog2(N_CH);
  localparam int OCC_W = $clog2(N_CH) + 1;

  typedef logic [WIDTH-1:0] chan_data_t;
  typedef logic [SEL_W-1:0] chan_sel_t;
  typedef logic [OCC_W-1:0] occ_t;
endpackage

// File: rtl/demux1a8w4_stream_if.sv
// Bus bundle for demux1a8w4_stream: one producer side and N_CH consumer sides.
// Handshake: a word moves on a side exactly in a cycle where its valid and ready are both 1;
// valid never waits on ready, and a held word stays stable until that cycle.
interface demux1a8w4_stream_if
  import demux_pkg::*;
#(
  parameter int WIDTH = demux_pkg::WIDTH,
  parameter int N_CH  = demux_pkg::N_CH
);
  localparam int SEL_W = $clog2(N_CH);
  localparam int OCC_W = $clog2(N_CH) + 1;

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SEL_W-1:0]   in_sel;
  logic [SEL_W-1:0]   cur_sel;
  logic [WIDTH-1:0]   out_data [N_CH];
  logic [N_CH-1:0]    out_valid;
  logic [N_CH-1:0]    out_ready;
  logic [OCC_W-1:0]   occupancy;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, cur_sel, out_data, out_valid, occupancy
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, cur_sel, out_data, out_valid, occupancy
  );
endinterface

// File: rtl/demux1a8w4_stream_chan_slot.sv
// One-entry holding register for a single output channel of demux1a8w4_stream.
module demux_chan_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = demux_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);
  // A load wins over a drain, so a same-cycle load+drain replaces the word and stays valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (out_ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/demux1a8w4_stream.sv
// Registered 1-to-N stream distributor. Define DEMUX_RR_SEL_EN to route by an
// internal round-robin pointer instead of in_sel.
module demux1a8w4_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = demux_pkg::WIDTH,
  parameter int N_CH  = demux_pkg::N_CH
) (
  input  logic                 clk,
  input  logic                 rst,
  demux1a8w4_stream_if.slave   bus
);
  localparam int SEL_W = $clog2(N_CH);
  localparam int OCC_W = $clog2(N_CH) + 1;

  logic [SEL_W-1:0] sel;
  logic             in_ready;
  logic             accept;
  logic [N_CH-1:0]  load;
  logic [N_CH-1:0]  valid;
  logic [N_CH-1:0]  nxt_valid;
  logic [WIDTH-1:0] data [N_CH];
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_nxt;

`ifdef DEMUX_RR_SEL_EN
  logic [SEL_W-1:0] rr_ptr;

  // The pointer only moves on an accept, so a full target channel stalls the stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= rr_ptr + SEL_W'(1);
    end
  end

  assign sel = rr_ptr;
`else
  assign sel = bus.in_sel;
`endif

  // A full channel that is draining this cycle can take the next word at once.
  assign in_ready = !rst && (!valid[sel] || bus.out_ready[sel]);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    load      = '0;
    nxt_valid = '0;
    occ_nxt   = '0;
    for (int k = 0; k < N_CH; k++) begin
      load[k]      = accept && (sel == SEL_W'(k));
      nxt_valid[k] = load[k] || (valid[k] && !bus.out_ready[k]);
      occ_nxt      = occ_nxt + OCC_W'(nxt_valid[k]);
    end
  end

  // Counting the next-state valids keeps occupancy aligned with out_valid every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_nxt;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_slot
    demux_chan_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load[k]),
      .load_data (bus.in_data),
      .out_ready (bus.out_ready[k]),
      .valid     (valid[k]),
      .data      (data[k])
    );
  end

  assign bus.in_ready  = in_ready;
  assign bus.cur_sel   = sel;
  assign bus.out_valid = valid;
  assign bus.out_data  = data;
  assign bus.occupancy = occ_q;
endmodule

// File: tb/tb_demux1a8w4_stream.sv
// Self-checking bench for demux1a8w4_stream; honours DEMUX_RR_SEL_EN when defined.
module tb_demux1a8w4_stream;
  import demux_pkg::*;

`ifdef DEMUX_RR_SEL_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  demux1a8w4_stream_if bus ();

  demux1a8w4_stream dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference state: which channels hold a word, what word, and the RR pointer.
  logic       m_full [N_CH];
  chan_data_t m_word [N_CH];
  chan_sel_t  m_ptr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N_CH-1:0] model_valid();
    logic [N_CH-1:0] v;
    for (int k = 0; k < N_CH; k++) v[k] = m_full[k];
    return v;
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int k = 0; k < N_CH; k++) c += m_full[k] ? 1 : 0;
    return c;
  endfunction

  // One clock: drive, check the combinational side, advance the model, check registered outputs.
  task automatic cycle(input logic r, input logic v, input chan_sel_t s,
                       input chan_data_t d, input logic [N_CH-1:0] rdy);
    chan_sel_t cs;
    logic      exp_rdy;
    rst           = r;
    bus.in_valid  = v;
    bus.in_sel    = s;
    bus.in_data   = d;
    bus.out_ready = rdy;
    #1;
    cs      = RR_MODE ? m_ptr : s;
    exp_rdy = !r && (!m_full[cs] || rdy[cs]);
    if (!r || !RR_MODE) chk("cur_sel", 32'(bus.cur_sel), 32'(cs));
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    if (r) begin
      for (int k = 0; k < N_CH; k++) begin
        m_full[k] = 1'b0;
        m_word[k] = '0;
      end
      m_ptr = '0;
    end else begin
      for (int k = 0; k < N_CH; k++) if (rdy[k]) m_full[k] = 1'b0;
      if (v && exp_rdy) begin
        m_full[cs] = 1'b1;
        m_word[cs] = d;
        m_ptr      = m_ptr + 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(bus.out_valid), 32'(model_valid()));
    chk("occupancy", 32'(bus.occupancy), 32'(model_count()));
    for (int k = 0; k < N_CH; k++) begin
      chk($sformatf("out_data[%0d]", k), 32'(bus.out_data[k]), 32'(m_word[k]));
    end
  endtask

  initial begin
    for (int k = 0; k < N_CH; k++) begin
      m_full[k] = 1'b0;
      m_word[k] = '0;
    end
    m_ptr         = '0;
    bus.in_valid  = 1'b0;
    bus.in_sel    = '0;
    bus.in_data   = '0;
    bus.out_ready = '0;

    // Reset held for two cycles with a word offered.
    cycle(1'b1, 1'b1, 3'd2, 4'h7, 8'h00);
    cycle(1'b1, 1'b1, 3'd2, 4'h7, 8'h00);
    chk("reset_occupancy", 32'(bus.occupancy), 32'd0);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);

`ifndef DEMUX_RR_SEL_EN
    // Route one word to channel 5.
    cycle(1'b0, 1'b1, 3'd5, 4'hA, 8'h00);
    chk("route_valid", 32'(bus.out_valid), 32'h20);
    chk("route_data5", 32'(bus.out_data[5]), 32'hA);
    chk("route_occ", 32'(bus.occupancy), 32'd1);

    // Backpressure: channel 5 is full and not draining.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, 3'd5, 4'h3, 8'h00);
      chk("bp_data5", 32'(bus.out_data[5]), 32'hA);
    end

    // Load and drain on the same channel in one cycle.
    rst = 1'b0; bus.in_valid = 1'b1; bus.in_sel = 3'd5; bus.in_data = 4'h3;
    bus.out_ready = 8'h20;
    #1;
    chk("ld_dr_in_ready", 32'(bus.in_ready), 32'd1);
    cycle(1'b0, 1'b1, 3'd5, 4'h3, 8'h20);
    chk("ld_dr_valid5", 32'(bus.out_valid[5]), 32'd1);
    chk("ld_dr_data5", 32'(bus.out_data[5]), 32'h3);
    chk("ld_dr_occ", 32'(bus.occupancy), 32'd1);

    // Empty, then fill all channels, then drain all at once.
    cycle(1'b0, 1'b0, 3'd0, 4'h0, 8'hFF);
    for (int k = 0; k < N_CH; k++) cycle(1'b0, 1'b1, chan_sel_t'(k), chan_data_t'(k), 8'h00);
    chk("fill_occ", 32'(bus.occupancy), 32'd8);
    chk("fill_valid", 32'(bus.out_valid), 32'hFF);
    cycle(1'b0, 1'b0, 3'd3, 4'h0, 8'hFF);
    chk("empty_valid", 32'(bus.out_valid), 32'd0);
    chk("empty_occ", 32'(bus.occupancy), 32'd0);
`else
    // Round-robin: eight words fill ch0..7, the ninth stalls on ch0.
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 3'd0, chan_data_t'(i + 1), 8'h00);
    chk("rr_occ", 32'(bus.occupancy), 32'd8);
    chk("rr_stall_ready", 32'(bus.in_ready), 32'd0);
    chk("rr_stall_sel", 32'(bus.cur_sel), 32'd0);
    chk("rr_ch0_word", 32'(bus.out_data[0]), 32'h1);
    chk("rr_ch7_word", 32'(bus.out_data[7]), 32'h8);
    // Draining ch0 lets the ninth word in and it lands on ch0.
    cycle(1'b0, 1'b1, 3'd4, 4'h9, 8'h01);
    chk("rr_ninth_ch0", 32'(bus.out_data[0]), 32'h9);
    chk("rr_wrap_sel", 32'(bus.cur_sel), 32'd1);
`endif

    // Random traffic with occasional mid-stream reset.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 3) != 0),
            chan_sel_t'($urandom_range(0, N_CH - 1)), chan_data_t'($urandom),
            (N_CH)'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
